// File: rtl/chad_spi_boot.sv
// ============================================================================
//  Module      : chad_spi_boot
//  Description : Loads chad's code RAM from an external SPI flash after reset.
//                It issues one mode-0 READ (0x03) transaction, assembles
//                big-endian 16-bit words, writes them to the code RAM, then
//                releases the processor reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module chad_spi_boot #(
  parameter int          CODE_WORDS = 1024,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          CLKDIV     = 2
) (
  input  logic        clk,
  input  logic        resetq,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [14:0] code_waddr,
  output logic [15:0] code_wdata,
  output logic        code_we,
  output logic        cpu_resetq,
  output logic        busy
);

  localparam int          DW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [14:0] LAST_WORD = 15'(CODE_WORDS - 1);
  localparam logic [31:0] HEADER    = {8'h03, FLASH_BASE};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_CMD      = 3'd2,
    S_DATA     = 3'd3,
    S_DESELECT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic [4:0]    cmd_cnt_q, cmd_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [14:0]   word_cnt_q, word_cnt_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          full_q, full_d;
  logic          load_done_q, load_done_d;
  logic          we_q, we_d;
  logic [14:0]   waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          cpu_q, cpu_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          is_last;
  logic          adv;

  assign tick    = (div_q == DIV_LAST);
  assign is_last = (word_cnt_q == LAST_WORD);

  assign spi_cs_n   = cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign code_we    = we_q;
  assign code_waddr = waddr_q;
  assign code_wdata = wdata_q;
  assign cpu_resetq = cpu_q;
  assign busy       = busy_q;

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_cnt_q   <= 5'd0;
      bit_cnt_q   <= 4'd0;
      word_cnt_q  <= 15'd0;
      shreg_q     <= 16'd0;
      full_q      <= 1'b0;
      load_done_q <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= 15'd0;
      wdata_q     <= 16'd0;
      cpu_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      cmd_cnt_q   <= cmd_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shreg_q     <= shreg_d;
      full_q      <= full_d;
      load_done_q <= load_done_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_q       <= cpu_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: SCK phase generator, header shift-out, word assembly.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    cmd_cnt_d   = cmd_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shreg_d     = shreg_q;
    full_d      = full_q;
    load_done_d = load_done_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_d       = cpu_q;
    busy_d      = busy_q;
    adv         = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d     = S_SELECT;
        cs_n_d      = 1'b0;
        mosi_d      = HEADER[31];
        div_d       = '0;
        sck_d       = 1'b0;
        cmd_cnt_d   = 5'd0;
        bit_cnt_d   = 4'd0;
        word_cnt_d  = 15'd0;
        full_d      = 1'b0;
        load_done_d = 1'b0;
      end

      // The SELECT cycle is also the first low cycle of header bit 31.
      S_SELECT: begin
        adv     = 1'b1;
        state_d = S_CMD;
      end

      S_CMD: begin
        adv = 1'b1;
        if (tick && sck_q) begin
          if (cmd_cnt_q == 5'd31) begin
            state_d = S_DATA;
            mosi_d  = 1'b0;
          end else begin
            cmd_cnt_d = cmd_cnt_q + 5'd1;
            mosi_d    = HEADER[5'd30 - cmd_cnt_q];
          end
        end
      end

      S_DATA: begin
        if (load_done_q) begin
          state_d = S_DESELECT;
          cs_n_d  = 1'b1;
        end else begin
          // After the final bit the clock parks low; no further edges.
          adv = !(full_q && is_last && !sck_q);
          if (tick && !sck_q) begin
            shreg_d   = {shreg_q[14:0], spi_miso};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              full_d = 1'b1;
            end
          end
          // Intermediate words write immediately; the last waits for SCK low.
          if (full_q && (!is_last || !sck_q)) begin
            we_d    = 1'b1;
            waddr_d = word_cnt_q;
            wdata_d = shreg_q;
            full_d  = 1'b0;
            if (is_last) begin
              load_done_d = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + 15'd1;
            end
          end
        end
      end

      S_DESELECT: begin
        state_d = S_DONE;
        cpu_d   = 1'b1;
        busy_d  = 1'b0;
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      if (tick) begin
        div_d = '0;
        sck_d = !sck_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/chad_spi_boot.md
# chad_spi_boot

Boot loader that fills chad's code RAM from an external SPI flash after reset, then releases the processor. It sits directly upstream of the chad core: it drives the write port of the code memory that chad later reads through `code_addr`/`insn`, and it holds chad's `resetq` low until the image is loaded. It implements one fixed SPI mode-0 READ (0x03) transaction per reset, with no software involvement.

## Interface
Parameters:
- `CODE_WORDS`, 1024: number of 16-bit instructions to load, range 1..32768.
- `FLASH_BASE`, 24'h000000: flash byte address of the image.
- `CLKDIV`, 2: `clk` cycles per SCK half-period, minimum 1.

Ports:
- `clk` in 1: system clock; the same clock as chad.
- `resetq` in 1: asynchronous, active-low reset. It restarts the whole boot.
- `spi_cs_n` out 1: flash chip select, active low.
- `spi_sck` out 1: SPI clock, mode 0 (idles low).
- `spi_mosi` out 1: command and address data, MSB first.
- `spi_miso` in 1: flash read data, already synchronous to `clk`.
- `code_waddr` out 15: code RAM write address, in words.
- `code_wdata` out 16: code RAM write data.
- `code_we` out 1: code RAM write strobe, one cycle per word.
- `cpu_resetq` out 1: drives chad's `resetq`; low while booting.
- `busy` out 1: high from reset until the load completes.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `code_we`=0, `code_waddr`=0, `code_wdata`=0, `cpu_resetq`=0, `busy`=1.
- States and transitions:
  - IDLE → SELECT on the first clock after reset deassertion.
  - SELECT (1 cycle): `spi_cs_n`=0, and `spi_mosi` = bit 31 of the header {8'h03, FLASH_BASE}.
  - CMD: shifts out the 32 header bits.
  - DATA: shifts in 16·CODE_WORDS bits.
  - DESELECT (1 cycle): `spi_cs_n`=1.
  - DONE: terminal; `busy`=0 and `cpu_resetq`=1 until the next reset.
- Bit timing: each bit is CLKDIV cycles with SCK low, then CLKDIV cycles with SCK high. MOSI changes only on the cycle SCK falls, or in SELECT for the first bit. MISO is registered on the cycle SCK rises.
- MOSI during DATA is 0.
- Word assembly: data is big-endian. The first byte received forms `code_wdata[15:8]`. Bits shift into a 16-bit register MSB first.
- After the 16th bit of word k is sampled:
  - The next cycle has `code_we`=1, `code_waddr`=k, and `code_wdata`=the word.
  - `code_waddr`/`code_wdata` hold until the next write.
- Bit counter: 4-bit within each word, plus a 15-bit word counter. The word counter ends at CODE_WORDS−1 without wrapping. CODE_WORDS=32768 is legal; the last address written is 0x7FFF.
- DATA → DESELECT occurs on the cycle the last word's `code_we` is high. SCK is already low by then, and no extra SCK edge is produced.
- `resetq` low mid-operation: all outputs return to their reset values asynchronously, and the boot restarts from word 0 after release. A partial image is harmless because `cpu_resetq` stays low.
- `spi_miso` is ignored outside DATA.

## Timing
- SCK period is 2·CLKDIV `clk` cycles.
- SELECT to the first SCK rise: CLKDIV cycles.
- The last SCK falls, then `code_we` for the last word occurs the following cycle.
- DESELECT follows for 1 cycle, and `cpu_resetq` rises one cycle after `spi_cs_n` rises.
- Total boot time from reset release to `cpu_resetq`=1 is 1 + 1 + 2·CLKDIV·(32 + 16·CODE_WORDS) + 2 cycles, ±1 cycle for the strobe slot; the bench pins the exact value from the counters.
- `code_we` is never high in two consecutive cycles when CLKDIV ≥ 1.
- `busy` and `cpu_resetq` change in the same cycle.

## Test plan
- Header: CLKDIV=1, FLASH_BASE=24'h012345, with a flash model. MOSI sampled on SCK rises → 32'h03012345; `spi_cs_n` is low throughout.
- Load: CODE_WORDS=2, flash bytes 8'hA5, 8'h5A, 8'h12, 8'h34.
  - Writes: (addr 0, 16'hA55A), then (addr 1, 16'h1234), each exactly one `code_we` cycle.
  - Then `spi_cs_n`=1, then `cpu_resetq`=1 and `busy`=0.
- Divider: CLKDIV=3. SCK high and low phases are each exactly 3 cycles, with 96 SCK rises for CODE_WORDS=4.
- Mid-boot reset: assert `resetq` during word 1 with CODE_WORDS=4.
  - Outputs go to their reset values immediately.
  - After release, a fresh 0x03 header is sent and writes restart at address 0.
- Done stability: after DONE, toggle `spi_miso` randomly for 1000 cycles. Expect no `code_we`, no SCK edges, and `cpu_resetq` remaining 1.
- End to end: chad plus code RAM, loading a 4-word program that writes a constant to I/O. chad's `io_wr` fires only after `cpu_resetq` rises, with the expected `dout`.
